// File: rtl/numeric_display_scan_if.sv
// numeric_display_scan_if
// Groups the control, data and display-pin signals of numeric_display_scan.
//   master : drives EN/DATA/DP/COLON/BLANK_LZ/UPDATE, observes PINS/DIGIT_IDX/FRAME_DONE
//   slave  : the display scanner itself
// Signals:
//   EN         display enable
//   DATA[15:0] hex value, nibble k -> digit k (digit 0 rightmost)
//   DP[3:0]    decimal point per digit
//   COLON[1:0] colon/apostrophe indicators
//   BLANK_LZ   leading-zero suppression enable
//   UPDATE     one-cycle strobe capturing DATA/DP/COLON/BLANK_LZ into pending
//   PINS[13:0] [6:0] seg a..g, [7] dp, [11:8] commons 0..3, [13:12] colon
//   DIGIT_IDX  digit currently in its slot
//   FRAME_DONE pulse on the last cycle of digit 3's slot
interface numeric_display_scan_if;
  logic        EN;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [1:0]  COLON;
  logic        BLANK_LZ;
  logic        UPDATE;
  logic [13:0] PINS;
  logic [1:0]  DIGIT_IDX;
  logic        FRAME_DONE;

  modport master (
    output EN, DATA, DP, COLON, BLANK_LZ, UPDATE,
    input  PINS, DIGIT_IDX, FRAME_DONE
  );

  modport slave (
    input  EN, DATA, DP, COLON, BLANK_LZ, UPDATE,
    output PINS, DIGIT_IDX, FRAME_DONE
  );
endinterface

// File: rtl/numeric_display_scan.sv
// numeric_display_scan
// Time-multiplexes a 4-digit multiplexed 7-segment display from a 16-bit hex
// value. Each digit gets a slot of DIV = C_CLK_FREQ_HZ/C_SCAN_HZ cycles; the
// first C_BLANK_CYCLES cycles of a slot keep all commons off (anti-ghosting)
// while the segments already carry the new pattern. The value is double
// buffered: UPDATE captures into a pending register, and the pending value is
// moved into the displayed shadow only at a frame start (digit 0, cycle 0).
// Ports:
//   CLK   clock
//   nRST  synchronous active-low reset
//   bus   numeric_display_scan_if.slave (inputs, PINS, DIGIT_IDX, FRAME_DONE)
module numeric_display_scan #(
  parameter int C_CLK_FREQ_HZ    = 10000000,
  parameter int C_SCAN_HZ        = 1000,
  parameter int C_BLANK_CYCLES   = 8,
  parameter bit C_SEG_ACTIVE_LOW = 1'b1,
  parameter bit C_DIG_ACTIVE_LOW = 1'b1
) (
  input logic                  CLK,
  input logic                  nRST,
  numeric_display_scan_if.slave bus
);

  localparam int DIV   = C_CLK_FREQ_HZ / C_SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(C_BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic SEG_INV = C_SEG_ACTIVE_LOW;
  localparam logic DIG_INV = C_DIG_ACTIVE_LOW;
  localparam logic [13:0] PINS_OFF = {{2{SEG_INV}}, {4{DIG_INV}}, SEG_INV, {7{SEG_INV}}};

  // The slot must hold the blanking guard plus at least one driven cycle.
  if (DIV < 2 || DIV <= C_BLANK_CYCLES + 1) begin : g_bad_params
    $error("numeric_display_scan: slot length must exceed blanking guard + 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [1:0]  colon;
    logic        blank_lz;
  } disp_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             frame_done_q, frame_done_d;
  disp_t            pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  disp_t            shadow_q, shadow_d;
  logic [13:0]      pins_q, pins_d;

  logic       frame_start;
  logic [3:0] nibble;
  logic       suppress;
  logic [6:0] seg_on;
  logic       dp_on;
  logic [3:0] com_on;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Next-state logic. PINS are computed from the *next* state/counter/shadow
  // so the registered outputs line up with the state registers exactly.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    digit_d         = digit_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    shadow_d        = shadow_q;
    frame_start     = 1'b0;

    if (!bus.EN) begin
      cnt_d   = '0;
      digit_d = 2'd0;
    end else if (state_q == ST_IDLE) begin
      cnt_d       = '0;
      digit_d     = 2'd0;
      frame_start = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      digit_d     = digit_q + 2'd1;
      frame_start = (digit_q == 2'd3);
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (!bus.EN) begin
      state_d = ST_IDLE;
    end else if (cnt_d < CNT_BLANK) begin
      state_d = ST_BLANK;
    end else begin
      state_d = ST_DRIVE;
    end

    // Shadow takes the value pending before this edge; an UPDATE arriving on
    // the same edge lands in pending and waits for the following frame.
    if (frame_start && pending_valid_q) begin
      shadow_d        = pending_q;
      pending_valid_d = 1'b0;
    end
    if (bus.UPDATE) begin
      pending_d.data     = bus.DATA;
      pending_d.dp       = bus.DP;
      pending_d.colon    = bus.COLON;
      pending_d.blank_lz = bus.BLANK_LZ;
      pending_valid_d    = 1'b1;
    end

    frame_done_d = (state_d != ST_IDLE) && (digit_d == 2'd3) && (cnt_d == CNT_LAST);

    nibble = shadow_d.data[{digit_d, 2'b00} +: 4];
    case (digit_d)
      2'd1:    suppress = shadow_d.blank_lz && (shadow_d.data[15:4] == 12'h000);
      2'd2:    suppress = shadow_d.blank_lz && (shadow_d.data[15:8] == 8'h00);
      2'd3:    suppress = shadow_d.blank_lz && (shadow_d.data[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase
    seg_on = suppress ? 7'h00 : hex_seg(nibble);
    dp_on  = suppress ? 1'b0 : shadow_d.dp[digit_d];
    com_on = (state_d == ST_DRIVE) ? (4'b0001 << digit_d) : 4'b0000;

    if (state_d == ST_IDLE) begin
      pins_d = PINS_OFF;
    end else begin
      pins_d = {shadow_d.colon ^ {2{SEG_INV}}, com_on ^ {4{DIG_INV}},
                dp_on ^ SEG_INV, seg_on ^ {7{SEG_INV}}};
    end
  end

  // Single register bank for the FSM, counters, buffers and all outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      digit_q         <= 2'd0;
      frame_done_q    <= 1'b0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shadow_q        <= '0;
      pins_q          <= PINS_OFF;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      digit_q         <= digit_d;
      frame_done_q    <= frame_done_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      shadow_q        <= shadow_d;
      pins_q          <= pins_d;
    end
  end

  assign bus.PINS       = pins_q;
  assign bus.DIGIT_IDX  = digit_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_numeric_display_scan.sv
// tb_numeric_display_scan
// Self-checking bench for numeric_display_scan with DIV=10, two blank cycles
// and active-low pins. A frame-position model (0..39 within a frame, plus
// pending/shadow copies of the displayed value) predicts PINS, DIGIT_IDX and
// FRAME_DONE every cycle; directed steps follow the test plan, then random
// values, update timing and enable drops exercise the same rules.
module tb_numeric_display_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  numeric_display_scan_if bus ();

  numeric_display_scan #(
    .C_CLK_FREQ_HZ   (1000),
    .C_SCAN_HZ       (100),
    .C_BLANK_CYCLES  (2),
    .C_SEG_ACTIVE_LOW(1'b1),
    .C_DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK (clk),
    .nRST(rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Held stimulus values
  logic        en_r  = 1'b0;
  logic [15:0] data_r = 16'h0;
  logic [3:0]  dp_r  = 4'h0;
  logic [1:0]  col_r = 2'b00;
  logic        lz_r  = 1'b0;

  // Reference model state
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] pd_data = 16'h0, sh_data = 16'h0;
  logic [3:0]  pd_dp = 4'h0,    sh_dp = 4'h0;
  logic [1:0]  pd_col = 2'b00,  sh_col = 2'b00;
  logic        pd_lz = 1'b0,    sh_lz = 1'b0;
  bit          pd_valid = 1'b0;
  int          fd_seen = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep(input logic upd);
    bit fs;
    fs = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_t = 0; pd_valid = 1'b0;
      pd_data = 16'h0; pd_dp = 4'h0; pd_col = 2'b00; pd_lz = 1'b0;
      sh_data = 16'h0; sh_dp = 4'h0; sh_col = 2'b00; sh_lz = 1'b0;
    end else begin
      if (!en_r) begin
        m_active = 1'b0; m_t = 0;
      end else if (!m_active) begin
        m_active = 1'b1; m_t = 0; fs = 1'b1;
      end else begin
        m_t = (m_t + 1) % 40;
        fs = (m_t == 0);
      end
      if (fs && pd_valid) begin
        sh_data = pd_data; sh_dp = pd_dp; sh_col = pd_col; sh_lz = pd_lz;
        pd_valid = 1'b0;
      end
      if (upd) begin
        pd_data = data_r; pd_dp = dp_r; pd_col = col_r; pd_lz = lz_r;
        pd_valid = 1'b1;
      end
    end
  endtask

  function automatic logic [13:0] expPins();
    int dig, cyc;
    logic sup;
    logic [6:0] seg;
    logic dpb;
    logic [3:0] com;
    if (!m_active) return 14'h3FFF;
    dig = m_t / 10;
    cyc = m_t % 10;
    sup = sh_lz && (dig > 0) && ((sh_data >> (4 * dig)) == 16'h0);
    seg = sup ? 7'h00 : seg_tab[4'((sh_data >> (4 * dig)) & 16'hF)];
    dpb = sup ? 1'b0 : sh_dp[dig];
    com = (cyc < 2) ? 4'h0 : 4'(1 << dig);
    return ~{sh_col, com, dpb, seg};
  endfunction

  task automatic checkConst(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [13:0] e_pins;
    logic [1:0]  e_idx;
    logic        e_fd;
    e_pins = expPins();
    e_idx  = m_active ? 2'(m_t / 10) : 2'd0;
    e_fd   = m_active && (m_t == 39);
    checks++;
    assert (bus.PINS === e_pins) else begin
      errors++;
      $error("[TB] FAIL pins t=%0d: observed %h expected %h", m_t, bus.PINS, e_pins);
    end
    checks++;
    assert (bus.DIGIT_IDX === e_idx) else begin
      errors++;
      $error("[TB] FAIL digit_idx t=%0d: observed %0d expected %0d", m_t, bus.DIGIT_IDX, e_idx);
    end
    checks++;
    assert (bus.FRAME_DONE === e_fd) else begin
      errors++;
      $error("[TB] FAIL frame_done t=%0d: observed %b expected %b", m_t, bus.FRAME_DONE, e_fd);
    end
    if (bus.FRAME_DONE === 1'b1) fd_seen++;
  endtask

  // One clock: drive inputs, clock edge, update model, check outputs.
  task automatic applyStimulus(input logic upd);
    bus.EN = en_r; bus.DATA = data_r; bus.DP = dp_r;
    bus.COLON = col_r; bus.BLANK_LZ = lz_r; bus.UPDATE = upd;
    @(posedge clk);
    modelStep(upd);
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic setValue(input logic [15:0] d, input logic [3:0] dp,
                          input logic [1:0] col, input logic lz);
    data_r = d; dp_r = dp; col_r = col; lz_r = lz;
  endtask

  initial begin
    bus.EN = 1'b0; bus.DATA = 16'h0; bus.DP = 4'h0;
    bus.COLON = 2'b00; bus.BLANK_LZ = 1'b0; bus.UPDATE = 1'b0;

    // 1: reset held, released with EN=0
    rst_n = 1'b0;
    runCycles(3);
    rst_n = 1'b1;
    runCycles(3);
    checkConst("reset_pins", {2'b00, bus.PINS}, 16'h3FFF);

    // 2: show 1234
    setValue(16'h1234, 4'h0, 2'b00, 1'b0);
    applyStimulus(1'b1);
    en_r = 1'b1;
    applyStimulus(1'b0);
    checkConst("d0_blank_com", {12'h0, bus.PINS[11:8]}, 16'h000F);
    checkConst("d0_blank_seg", {9'h0, bus.PINS[6:0]}, 16'h0019);
    runCycles(2);
    checkConst("d0_drive_com", {12'h0, bus.PINS[11:8]}, 16'h000E);
    runCycles(30);
    checkConst("d3_seg", {9'h0, bus.PINS[6:0]}, 16'h0079);
    checkConst("d3_com", {12'h0, bus.PINS[11:8]}, 16'h0007);
    fd_seen = 0;
    runCycles(80);
    checkConst("fd_count", 16'(fd_seen), 16'd2);

    // 3: leading-zero suppression, then all-zero value
    setValue(16'h0050, 4'h0, 2'b01, 1'b1);
    applyStimulus(1'b1);
    runCycles(80);
    setValue(16'h0000, 4'hF, 2'b10, 1'b1);
    applyStimulus(1'b1);
    runCycles(80);

    // 4: two updates inside one frame, last wins
    runCycles(5);
    setValue(16'hABCD, 4'h5, 2'b11, 1'b0);
    applyStimulus(1'b1);
    runCycles(4);
    setValue(16'h0001, 4'h0, 2'b00, 1'b0);
    applyStimulus(1'b1);
    runCycles(80);

    // 5: EN drop during digit 2 drive
    for (int i = 0; i < 100 && !(m_active && m_t == 25); i++) applyStimulus(1'b0);
    checkConst("align_d2", {14'h0, bus.DIGIT_IDX}, 16'd2);
    en_r = 1'b0;
    applyStimulus(1'b0);
    checkConst("en_off_pins", {2'b00, bus.PINS}, 16'h3FFF);
    runCycles(2);
    en_r = 1'b1;
    applyStimulus(1'b0);
    checkConst("reen_idx", {14'h0, bus.DIGIT_IDX}, 16'd0);
    checkConst("reen_com", {12'h0, bus.PINS[11:8]}, 16'h000F);
    runCycles(45);

    // 6: reset mid-frame with pending set
    setValue(16'h5A5A, 4'hA, 2'b11, 1'b0);
    applyStimulus(1'b1);
    runCycles(3);
    rst_n = 1'b0;
    applyStimulus(1'b0);
    checkConst("rst_mid_pins", {2'b00, bus.PINS}, 16'h3FFF);
    rst_n = 1'b1;
    runCycles(3);
    checkConst("post_rst_seg", {9'h0, bus.PINS[6:0]}, 16'h0040);
    runCycles(80);

    // 7: random values, update timing and enable drops
    for (int it = 0; it < 30; it++) begin
      setValue(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
               2'($urandom), 1'($urandom_range(0, 1)));
      applyStimulus(1'b1);
      runCycles($urandom_range(3, 60));
      if ($urandom_range(0, 7) == 0) begin
        en_r = 1'b0;
        runCycles($urandom_range(1, 3));
        en_r = 1'b1;
      end
    end
    runCycles(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
